// File: rtl/aes_key_expand_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry key store with an indexed read port.
// Optional build macro AES_KEY_ZEROIZE_EN zeroes the key store on reset, on clear, and on each new expansion.
module aes_key_expand_ctrl #(
  parameter int NR     = 10,
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         clear,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  // state  | meaning
  // IDLE   | no key loaded, ready for a key
  // EXPAND | computing round keys 1..10, one per cycle
  // DONE   | all 11 round keys stored, ready for a reload

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_key_expand_ctrl supports only NR=10 (AES-128)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    // entry 0 sits in the top byte, so ~x selects the byte counted from the LSB end
    base = {~x, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         state;
  logic [3:0]     round;
  logic [7:0]     rcon;
  logic [127:0]   store [0:10];
  logic           accept;
  logic [127:0]   prev_key;
  logic [31:0]    rot_word;
  logic [31:0]    t_word;
  logic [31:0]    e_w, f_w, g_w, h_w;
  logic [127:0]   next_key;
  logic           rd_oob;
  logic [127:0]   rd_word;

  assign accept = key_valid && key_ready && !clear && !rst;

  always_comb begin
    prev_key = store[round - 4'd1];
    rot_word = {prev_key[23:0], prev_key[31:24]};
    t_word   = {sbox(rot_word[31:24]) ^ rcon, sbox(rot_word[23:16]),
                sbox(rot_word[15:8]), sbox(rot_word[7:0])};
    e_w      = prev_key[127:96] ^ t_word;
    f_w      = prev_key[95:64] ^ e_w;
    g_w      = prev_key[63:32] ^ f_w;
    h_w      = prev_key[31:0] ^ g_w;
    next_key = {e_w, f_w, g_w, h_w};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      round      <= 4'd0;
      rcon       <= 8'h01;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      round      <= 4'd0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state      <= EXPAND;
            round      <= 4'd1;
            rcon       <= 8'h01;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          rcon <= xtime(rcon);
          if (round == LAST_ROUND) begin
            state      <= DONE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          round     <= 4'd0;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_KEY_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else if (accept) begin
      store[0] <= key_in;
      for (int i = 1; i < 11; i++) store[i] <= '0;
    end else if (state == EXPAND) begin
      store[round] <= next_key;
    end
  end
`else
  // stale entries survive reset/clear; keys_valid is the only qualifier
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      if (accept) begin
        store[0] <= key_in;
      end else if (state == EXPAND) begin
        store[round] <= next_key;
      end
    end
  end
`endif

  assign rd_oob  = rd_idx > LAST_ROUND;
  assign rd_word = rd_oob ? '0 : store[rd_idx];

  generate
    if (RD_REG) begin : g_rd_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_key <= '0;
          rd_err <= 1'b0;
        end else if (rd_en) begin
          rd_key <= rd_word;
          rd_err <= rd_oob;
        end
      end
    end else begin : g_rd_comb
      assign rd_key = rd_word;
      assign rd_err = rd_oob;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl (RD_REG=1) with a FIPS-197 word-level reference model.
module tb_aes_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         clear;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_err;

  aes_key_expand_ctrl #(.NR(10), .RD_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .clear(clear), .busy(busy), .keys_valid(keys_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference model: S-box derived from the GF(2^8) inverse plus affine map
  logic [7:0]   m_sbox [0:255];
  logic [127:0] m_keys [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  bit           m_init = 0;
  bit           m_exp;
  bit           m_valid;
  int           m_r;
  bit           m_known [0:10];
  logic [127:0] m_val [0:10];
  bit           m_rd_known;
  logic [127:0] m_rd_key;
  logic         m_rd_err;

  initial for (int i = 0; i < 11; i++) m_known[i] = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_exp = 0; m_valid = 0; m_r = 0;
      m_rd_key = '0; m_rd_err = 1'b0; m_rd_known = 1;
`ifdef AES_KEY_ZEROIZE_EN
      for (int i = 0; i < 11; i++) begin m_known[i] = 1; m_val[i] = '0; end
`endif
    end else if (m_init) begin
      if (rd_en) begin
        if (rd_idx > 4'd10) begin
          m_rd_key = '0; m_rd_err = 1'b1; m_rd_known = 1;
        end else begin
          m_rd_err = 1'b0; m_rd_known = m_known[rd_idx]; m_rd_key = m_val[rd_idx];
        end
      end
      if (clear) begin
        m_exp = 0; m_valid = 0;
`ifdef AES_KEY_ZEROIZE_EN
        for (int i = 0; i < 11; i++) begin m_known[i] = 1; m_val[i] = '0; end
`endif
      end else if (!m_exp && key_valid) begin
        model_expand(key_in);
        m_val[0] = key_in; m_known[0] = 1;
`ifdef AES_KEY_ZEROIZE_EN
        for (int i = 1; i < 11; i++) begin m_known[i] = 1; m_val[i] = '0; end
`endif
        m_exp = 1; m_valid = 0; m_r = 1;
      end else if (m_exp) begin
        m_val[m_r] = m_keys[m_r]; m_known[m_r] = 1;
        if (m_r == 10) begin m_exp = 0; m_valid = 1; end
        else m_r++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("key_ready", key_ready, !m_exp);
      chk("busy", busy, m_exp);
      chk("keys_valid", keys_valid, m_valid);
      chk("rd_err", rd_err, m_rd_err);
      if (m_rd_known) chk("rd_key", rd_key, m_rd_key);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_en = 1'b1; rd_idx = idx;
    tick;
    rd_en = 1'b0;
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_valid = 1'b1; key_in = k;
    tick;
    key_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!keys_valid && n < 30) begin tick; n++; end
    chk("wait_done_timeout", 1'(n < 30), 1'b1);
  endtask

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ONES = {128{1'b1}};

  initial begin
    int n;
    rst = 1'b1; key_valid = 1'b0; key_in = '0; clear = 1'b0; rd_en = 1'b0; rd_idx = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_keys_valid", keys_valid, 1'b0);
    chk("rst_rd_key", rd_key, '0);
    chk("rst_rd_err", rd_err, 1'b0);
    tick;

    // FIPS-197 vector and accept-to-keys_valid latency
    accept_key(K_FIPS);
    chk("model_rk0", m_keys[0], K_FIPS);
    chk("model_rk1", m_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_rk10", m_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    n = 0;
    while (!keys_valid && n < 30) begin tick; n++; end
    chk("fips_latency", 128'(n), 128'd10);
    rd(4'd0);  chk("fips_rk0", rd_key, K_FIPS);
    rd(4'd1);  chk("fips_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10); chk("fips_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd3;
    tick; tick;
    chk("rd_hold", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd12);
    chk("oob_key", rd_key, '0);
    chk("oob_err", rd_err, 1'b1);
    rd(4'd5);
    chk("inb_err", rd_err, 1'b0);

    // back-pressure: second key held during the whole expansion
    key_valid = 1'b1; key_in = 128'h000102030405060708090a0b0c0d0e0f;
    tick;
    key_in = K_FIPS;
    n = 0;
    while (!key_ready && n < 30) begin n++; tick; end
    chk("bp_ready_low_cycles", 128'(n), 128'd10);
    chk("bp_done_valid", keys_valid, 1'b1);
    tick;
    key_valid = 1'b0;
    chk("bp_reload_valid_drop", keys_valid, 1'b0);
    chk("bp_reload_busy", busy, 1'b1);
    wait_done;
    rd(4'd10); chk("bp_second_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // clear mid-expansion, with a competing key
    accept_key(K_FIPS);
    repeat (5) tick;
    clear = 1'b1; key_valid = 1'b1; key_in = K_ONES;
    tick;
    chk("clr_busy", busy, 1'b0);
    chk("clr_keys_valid", keys_valid, 1'b0);
    chk("clr_key_ready", key_ready, 1'b1);
    clear = 1'b0; key_valid = 1'b0;
    tick;
    chk("clr_no_accept", busy, 1'b0);
`ifdef AES_KEY_ZEROIZE_EN
    for (int i = 0; i < 11; i++) begin
      rd(4'(i));
      chk("zeroize_rd", rd_key, '0);
    end
`endif

    // reset mid-expansion, then all-zero key
    accept_key(K_FIPS);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_key_ready", key_ready, 1'b1);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_keys_valid", keys_valid, 1'b0);
    chk("rst2_rd_key", rd_key, '0);
    chk("rst2_rd_err", rd_err, 1'b0);
    accept_key('0);
    wait_done;
    rd(4'd10); chk("zero_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // reload from DONE
    accept_key(K_ONES);
    chk("reload_valid_drop", keys_valid, 1'b0);
    chk("model_ones_rk1", m_keys[1], 128'he8e9e9e917161616e8e9e9e917161616);
    wait_done;
    rd(4'd1); chk("ones_rk1", rd_key, 128'he8e9e9e917161616e8e9e9e917161616);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
